drop_move_scheduler: RTL and testbench

// Sequences the falling Tetris piece. Generates the gravity tick at a rate set by the
// 2-bit difficulty code (00 easy, 01 medium, 10 hard) and arbitrates gravity and four

---
 rtl/drop_move_scheduler.sv | 173 +++++++++++++++++
 tb/tb_drop_move_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drop_move_scheduler.sv
// Falling-piece scheduler: generates the gravity tick for the selected difficulty
// and funnels gravity plus player requests onto a single command port to the board.
module drop_move_scheduler #(
    parameter int unsigned PERIOD_EASY   = 25_000_000,
    parameter int unsigned PERIOD_MEDIUM = 12_500_000,
    parameter int unsigned PERIOD_HARD   = 6_250_000,
    parameter int unsigned CNT_W         = 25
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       run_i,
    input  logic       pause_i,
    input  logic [1:0] difficulty_i,
    input  logic       mv_left_i,
    input  logic       mv_right_i,
    input  logic       mv_rot_i,
    input  logic       mv_soft_i,
    output logic       cmd_valid_o,
    output logic [1:0] cmd_op_o,
    input  logic       cmd_ready_i,
    input  logic       cmd_ok_i,
    output logic       lock_piece_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ISSUE,
        ST_LOCK
    } state_e;

    localparam logic [1:0] OP_DOWN  = 2'b00;
    localparam logic [1:0] OP_LEFT  = 2'b01;
    localparam logic [1:0] OP_RIGHT = 2'b10;
    localparam logic [1:0] OP_ROT   = 2'b11;

    // Bit positions inside the pending-flag vector
    localparam int F_GRAV  = 0;
    localparam int F_SOFT  = 1;
    localparam int F_ROT   = 2;
    localparam int F_LEFT  = 3;
    localparam int F_RIGHT = 4;

    localparam logic [CNT_W-1:0] LIM_EASY   = CNT_W'(PERIOD_EASY - 1);
    localparam logic [CNT_W-1:0] LIM_MEDIUM = CNT_W'(PERIOD_MEDIUM - 1);
    localparam logic [CNT_W-1:0] LIM_HARD   = CNT_W'(PERIOD_HARD - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       pend_q, pend_d;
    logic [4:0]       sel_q, sel_d;
    logic [1:0]       op_q, op_d;

    logic [CNT_W-1:0] limit;
    logic             counting;
    logic             tick;
    logic             xfer;
    logic [4:0]       player_set;
    logic [4:0]       pend_upd;
    logic [4:0]       remain;

    // Fixed-priority pick: returns {flags consumed, op}. Gravity and soft drop
    // share the DOWN op, so one DOWN consumes both when both are waiting.
    function automatic logic [6:0] pick(input logic [4:0] flags);
        logic [6:0] r;
        r = {5'b00000, OP_DOWN};
        if (flags[F_GRAV] || flags[F_SOFT]) begin
            r = {flags & 5'b00011, OP_DOWN};
        end else if (flags[F_ROT]) begin
            r = {5'b00100, OP_ROT};
        end else if (flags[F_LEFT]) begin
            r = {5'b01000, OP_LEFT};
        end else if (flags[F_RIGHT]) begin
            r = {5'b10000, OP_RIGHT};
        end
        return r;
    endfunction

    // Gravity period for the current difficulty; code 11 runs at the hard rate
    always_comb begin
        limit = LIM_HARD;
        case (difficulty_i)
            2'b00:   limit = LIM_EASY;
            2'b01:   limit = LIM_MEDIUM;
            default: limit = LIM_HARD;
        endcase
    end

    // The >= compare catches a count left above the limit when difficulty rises mid-period
    assign counting   = ((state_q == ST_WAIT) || (state_q == ST_ISSUE)) && !pause_i;
    assign tick       = counting && (cnt_q >= limit);
    assign xfer       = (state_q == ST_ISSUE) && cmd_ready_i;
    assign player_set = ((state_q != ST_IDLE) && !pause_i)
                        ? {mv_right_i, mv_left_i, mv_rot_i, mv_soft_i, 1'b0} : 5'b00000;
    assign pend_upd   = (pend_q & ~(xfer ? sel_q : 5'b00000)) | player_set | {4'b0000, tick};
    assign remain     = pend_q & ~sel_q;

    // Next-state logic: counter, pending flags, command selection and the FSM itself
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        sel_d   = sel_q;
        op_d    = op_q;

        if (counting) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (run_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                pend_d = pend_upd;
                if (!pause_i && (pend_q != 5'b00000)) begin
                    state_d       = ST_ISSUE;
                    {sel_d, op_d} = pick(pend_q);
                end
            end
            ST_ISSUE: begin
                pend_d = pend_upd;
                if (xfer) begin
                    if ((op_q == OP_DOWN) && !cmd_ok_i) begin
                        state_d = ST_LOCK;
                    end else if (!pause_i && (remain != 5'b00000)) begin
                        {sel_d, op_d} = pick(remain);
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_LOCK: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
                pend_d  = 5'b00000;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!run_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            pend_d  = 5'b00000;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= 5'b00000;
            sel_q   <= 5'b00000;
            op_q    <= OP_DOWN;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            op_q    <= op_d;
        end
    end

    assign cmd_valid_o  = (state_q == ST_ISSUE);
    assign cmd_op_o     = op_q;
    assign lock_piece_o = (state_q == ST_LOCK);

endmodule

// File: tb/tb_drop_move_scheduler.sv
// Scoreboard bench for drop_move_scheduler with short gravity periods (8/4/2).
// Cycle c means "after the c-th rising edge"; expected events carry their cycle.
module tb_drop_move_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       pause;
    logic [1:0] difficulty;
    logic       mvLeft;
    logic       mvRight;
    logic       mvRot;
    logic       mvSoft;
    logic       cmdValid;
    logic [1:0] cmdOp;
    logic       cmdReady;
    logic       cmdOk;
    logic       lockPiece;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         isLock;
        logic [1:0] op;
        int         cycle;
    } exp_t;

    exp_t  expQ[$];
    string expName[$];

    drop_move_scheduler #(
        .PERIOD_EASY  (8),
        .PERIOD_MEDIUM(4),
        .PERIOD_HARD  (2),
        .CNT_W        (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .run_i       (run),
        .pause_i     (pause),
        .difficulty_i(difficulty),
        .mv_left_i   (mvLeft),
        .mv_right_i  (mvRight),
        .mv_rot_i    (mvRot),
        .mv_soft_i   (mvSoft),
        .cmd_valid_o (cmdValid),
        .cmd_op_o    (cmdOp),
        .cmd_ready_i (cmdReady),
        .cmd_ok_i    (cmdOk),
        .lock_piece_o(lockPiece)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Cycle index used to timestamp both expectations and observed events
    always @(posedge clk) cyc <= cyc + 1;

    // Queue one expected command transfer (op) at an absolute cycle
    task automatic expectCmd(input logic [1:0] op, input int cycle, input string name);
        exp_t e;
        e.isLock = 1'b0;
        e.op     = op;
        e.cycle  = cycle;
        expQ.push_back(e);
        expName.push_back(name);
    endtask

    // Queue one expected lock_piece pulse at an absolute cycle
    task automatic expectLock(input int cycle, input string name);
        exp_t e;
        e.isLock = 1'b1;
        e.op     = 2'b00;
        e.cycle  = cycle;
        expQ.push_back(e);
        expName.push_back(name);
    endtask

    // Compare one observed DUT event against the head of the scoreboard
    task automatic checkOutput(input bit isLock, input logic [1:0] op);
        exp_t  e;
        string nm;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_event got lock=%0d op=%0d at cycle %0d, required no event",
                     isLock, op, cyc);
        end else begin
            e  = expQ.pop_front();
            nm = expName.pop_front();
            if ((e.isLock != isLock) || (!isLock && (e.op != op)) || (e.cycle != cyc)) begin
                errors++;
                $display("[TB] FAIL %s got lock=%0d op=%0d cycle=%0d, required lock=%0d op=%0d cycle=%0d",
                         nm, isLock, op, cyc, e.isLock, e.op, e.cycle);
            end
        end
    endtask

    // Direct comparison of a sampled output value
    task automatic checkValue(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s got %0d, required %0d at cycle %0d", name, actual, required, cyc);
        end
    endtask

    // Advance to just after the rising edge that starts the target cycle
    task automatic gotoCycle(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start a game at the current cycle; returns that cycle as the test origin
    task automatic applyStimulus(input logic [1:0] diff, output int c0);
        difficulty = diff;
        run        = 1'b1;
        c0         = cyc;
    endtask

    // Drop run so the DUT returns to IDLE at the next cycle
    task automatic endTest();
        run = 1'b0;
        gotoCycle(cyc + 1);
    endtask

    // Monitor: every transfer or lock pulse is checked against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (cmdValid && cmdReady) checkOutput(1'b0, cmdOp);
            if (lockPiece)            checkOutput(1'b1, 2'b00);
        end
    end

    // Directed stimulus; expected events are queued at the start of each test
    initial begin
        int c0;
        rst        = 1'b1;
        run        = 1'b0;
        pause      = 1'b0;
        difficulty = 2'b00;
        mvLeft     = 1'b0;
        mvRight    = 1'b0;
        mvRot      = 1'b0;
        mvSoft     = 1'b0;
        cmdReady   = 1'b1;
        cmdOk      = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkValue("reset_cmd_valid", int'(cmdValid), 0);
        checkValue("reset_cmd_op", int'(cmdOp), 0);
        checkValue("reset_lock_piece", int'(lockPiece), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Easy gravity: DOWN every 8 cycles, never a lock
        applyStimulus(2'b00, c0);
        expectCmd(2'b00, c0 + 10, "t1_down1");
        expectCmd(2'b00, c0 + 18, "t1_down2");
        expectCmd(2'b00, c0 + 26, "t1_down3");
        gotoCycle(c0 + 28);
        endTest();

        // Hard gravity, third DOWN rejected -> lock, then gravity restarts from zero
        applyStimulus(2'b10, c0);
        expectCmd(2'b00, c0 + 4, "t2_down1");
        expectCmd(2'b00, c0 + 6, "t2_down2");
        expectCmd(2'b00, c0 + 8, "t2_down3_rejected");
        expectLock(c0 + 9, "t2_lock");
        expectCmd(2'b00, c0 + 13, "t2_down_after_lock");
        gotoCycle(c0 + 8);
        cmdOk = 1'b0;
        gotoCycle(c0 + 9);
        cmdOk = 1'b1;
        gotoCycle(c0 + 10);
        checkValue("t2_lock_one_cycle", int'(lockPiece), 0);
        checkValue("t2_valid_after_lock", int'(cmdValid), 0);
        gotoCycle(c0 + 14);
        endTest();

        // ROT+LEFT together (LEFT rejected silently), then SOFT+RIGHT racing gravity
        applyStimulus(2'b00, c0);
        expectCmd(2'b11, c0 + 4, "t3_rot");
        expectCmd(2'b01, c0 + 5, "t3_left");
        expectCmd(2'b00, c0 + 8, "t3_soft");
        expectCmd(2'b10, c0 + 9, "t3_right");
        expectCmd(2'b00, c0 + 10, "t3_grav");
        gotoCycle(c0 + 2);
        mvRot  = 1'b1;
        mvLeft = 1'b1;
        gotoCycle(c0 + 3);
        mvRot  = 1'b0;
        mvLeft = 1'b0;
        gotoCycle(c0 + 5);
        cmdOk = 1'b0;
        gotoCycle(c0 + 6);
        cmdOk   = 1'b1;
        mvSoft  = 1'b1;
        mvRight = 1'b1;
        gotoCycle(c0 + 7);
        mvSoft  = 1'b0;
        mvRight = 1'b0;
        gotoCycle(c0 + 11);
        endTest();

        // Medium gravity and soft drop arriving together -> a single DOWN
        applyStimulus(2'b01, c0);
        expectCmd(2'b00, c0 + 6, "t7_grav_soft_merged");
        expectCmd(2'b00, c0 + 10, "t7_next_grav");
        gotoCycle(c0 + 4);
        mvSoft = 1'b1;
        gotoCycle(c0 + 5);
        mvSoft = 1'b0;
        gotoCycle(c0 + 11);
        endTest();

        // LEFT stalled by cmd_ready=0, three RIGHT pulses coalesce into one
        applyStimulus(2'b00, c0);
        expectCmd(2'b01, c0 + 8, "t4_left");
        expectCmd(2'b10, c0 + 9, "t4_right_once");
        expectCmd(2'b00, c0 + 10, "t4_grav");
        gotoCycle(c0 + 1);
        mvLeft = 1'b1;
        gotoCycle(c0 + 2);
        mvLeft = 1'b0;
        for (int k = 3; k <= 7; k++) begin
            gotoCycle(c0 + k);
            cmdReady = 1'b0;
            mvRight  = (k >= 4) && (k <= 6);
            checkValue($sformatf("t4_hold_valid_%0d", k), int'(cmdValid), 1);
            checkValue($sformatf("t4_hold_op_%0d", k), int'(cmdOp), 1);
        end
        gotoCycle(c0 + 8);
        mvRight  = 1'b0;
        cmdReady = 1'b1;
        gotoCycle(c0 + 11);
        endTest();

        // Pause for 20 cycles at count 3: nothing issued, requests ignored, count resumes
        applyStimulus(2'b00, c0);
        expectCmd(2'b00, c0 + 30, "t5_grav_after_pause");
        for (int k = 4; k <= 23; k++) begin
            gotoCycle(c0 + k);
            pause  = 1'b1;
            mvLeft = (k == 6);
            mvRot  = (k == 10);
            mvSoft = (k == 15);
            checkValue($sformatf("t5_paused_valid_%0d", k), int'(cmdValid), 0);
        end
        gotoCycle(c0 + 24);
        pause  = 1'b0;
        mvLeft = 1'b0;
        mvRot  = 1'b0;
        mvSoft = 1'b0;
        gotoCycle(c0 + 31);
        endTest();

        // Difficulty raised at count 6 -> immediate tick; run dropped mid-handshake
        applyStimulus(2'b00, c0);
        expectCmd(2'b00, c0 + 14, "t6_down_after_restart");
        gotoCycle(c0 + 7);
        difficulty = 2'b10;
        gotoCycle(c0 + 9);
        checkValue("t6_early_tick_valid", int'(cmdValid), 1);
        checkValue("t6_early_tick_op", int'(cmdOp), 0);
        cmdReady = 1'b0;
        run      = 1'b0;
        gotoCycle(c0 + 10);
        checkValue("t6_valid_dropped", int'(cmdValid), 0);
        checkValue("t6_no_lock", int'(lockPiece), 0);
        cmdReady = 1'b1;
        run      = 1'b1;
        gotoCycle(c0 + 15);
        endTest();

        gotoCycle(cyc + 5);
        while (expQ.size() > 0) begin
            exp_t  e;
            string nm;
            e  = expQ.pop_front();
            nm = expName.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL %s got no event, required lock=%0d op=%0d cycle=%0d",
                     nm, e.isLock, e.op, e.cycle);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
